// File: rtl/except_unit.sv
// MEM/WB exception commit unit: prioritises exception flags and interrupts, then issues a one-cycle CP0 request plus a timed flush/redirect.
// Optional EXC_INT_SYNC_EN: int_i goes through a two-flop synchronizer instead of a combinational pass-through.
module except_unit #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_i,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_excepttype_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [5:0]  int_sync_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o
);

   typedef enum logic {IDLE, FLUSH} state_t;

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

`ifdef EXC_INT_SYNC_EN
   logic [5:0] sync1_q, sync2_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 6'd0;
         sync2_q <= 6'd0;
      end else begin
         sync1_q <= int_i;
         sync2_q <= sync1_q;
      end
   end
   assign int_sync_o = sync2_q;
`else
   assign int_sync_o = int_i;
`endif

   logic [31:0] status_eff, epc_eff;
   logic [7:0]  cause_ip;
   logic        int_pend;
   logic [31:0] exc_code;

   // Same-cycle WB writes to CP0 must be visible to this instruction's decision.
   always_comb begin
      status_eff = cp0_status_i;
      cause_ip   = {int_sync_o, cp0_cause_i[9:8]};
      epc_eff    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         case (wb_cp0_waddr_i)
            5'd12:   status_eff = wb_cp0_data_i;
            5'd13:   cause_ip[1:0] = wb_cp0_data_i[9:8];
            5'd14:   epc_eff = wb_cp0_data_i;
            default: ;
         endcase
      end
   end

   assign int_pend = (|(cause_ip & status_eff[15:8])) & status_eff[0] & ~status_eff[1];

   always_comb begin
      exc_code = 32'h0;
      if (int_pend)                  exc_code = 32'h1;
      else if (mem_excepttype_i[8])  exc_code = 32'h8;
      else if (mem_excepttype_i[9])  exc_code = 32'ha;
      else if (mem_excepttype_i[10]) exc_code = 32'hd;
      else if (mem_excepttype_i[11]) exc_code = 32'hc;
      else if (mem_excepttype_i[12]) exc_code = 32'he;
   end

   logic        unused_ok;
   assign unused_ok = ^{cp0_cause_i[31:16], cp0_cause_i[7:0], status_eff[31:16],
                        status_eff[7:2], mem_excepttype_i[31:13], mem_excepttype_i[7:0]};

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] excepttype_q, excepttype_d;
   logic [31:0] addr_q, addr_d;
   logic        ds_q, ds_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      excepttype_d = excepttype_q;
      addr_d       = addr_q;
      ds_d         = ds_q;
      flush_d      = flush_q;
      new_pc_d     = new_pc_q;
      case (state_q)
         IDLE: begin
            if (mem_valid_i && exc_code != 32'h0) begin
               state_d      = FLUSH;
               cnt_d        = CNT_INIT;
               excepttype_d = exc_code;
               addr_d       = mem_pc_i;
               ds_d         = mem_in_delayslot_i;
               flush_d      = 1'b1;
               new_pc_d     = (exc_code == 32'he) ? epc_eff : EXC_VECTOR;
            end else begin
               cnt_d        = 4'd0;
               excepttype_d = 32'h0;
               addr_d       = 32'h0;
               ds_d         = 1'b0;
               flush_d      = 1'b0;
               new_pc_d     = 32'h0;
            end
         end
         FLUSH: begin
            // CP0 must see the code for exactly one edge.
            excepttype_d = 32'h0;
            if (cnt_q == 4'd0) begin
               state_d  = IDLE;
               addr_d   = 32'h0;
               ds_d     = 1'b0;
               flush_d  = 1'b0;
               new_pc_d = 32'h0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         excepttype_q <= 32'h0;
         addr_q       <= 32'h0;
         ds_q         <= 1'b0;
         flush_q      <= 1'b0;
         new_pc_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         excepttype_q <= excepttype_d;
         addr_q       <= addr_d;
         ds_q         <= ds_d;
         flush_q      <= flush_d;
         new_pc_q     <= new_pc_d;
      end
   end

   assign excepttype_o        = excepttype_q;
   assign current_inst_addr_o = addr_q;
   assign is_in_delayslot_o   = ds_q;
   assign flush_o             = flush_q;
   assign new_pc_o            = new_pc_q;
   assign busy_o              = (state_q == FLUSH);

endmodule

// File: tb/tb_except_unit.sv
// Randomised and directed bench for except_unit against a cycle-level behavioural model.
module tb_except_unit;

   localparam logic [31:0] VEC = 32'h0000_0020;
   localparam int          FC  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  int_i;
   logic        mem_valid_i;
   logic [31:0] mem_excepttype_i, mem_pc_i;
   logic        mem_in_delayslot_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [5:0]  int_sync_o;
   logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
   logic        is_in_delayslot_o, flush_o, busy_o;

   except_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .int_i(int_i), .mem_valid_i(mem_valid_i),
      .mem_excepttype_i(mem_excepttype_i), .mem_pc_i(mem_pc_i),
      .mem_in_delayslot_i(mem_in_delayslot_i), .cp0_status_i(cp0_status_i),
      .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i),
      .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
      .int_sync_o(int_sync_o), .excepttype_o(excepttype_o),
      .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
      .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: cycles of flush still visible, and the expected registered outputs.
   int          rem = 0;
   logic [31:0] e_exc = 0, e_addr = 0, e_npc = 0;
   logic        e_ds = 0;
   logic [5:0]  m_s1 = 0, m_s2 = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] model_sync();
`ifdef EXC_INT_SYNC_EN
      return m_s2;
`else
      return int_i;
`endif
   endfunction

   task automatic model_reset();
      rem = 0; e_exc = 0; e_addr = 0; e_npc = 0; e_ds = 0; m_s1 = 0; m_s2 = 0;
   endtask

   task automatic model_edge();
      logic [31:0] status, epc, code;
      logic [7:0]  pend;
      logic [1:0]  sw_ip;
      status = cp0_status_i;
      epc    = cp0_epc_i;
      sw_ip  = cp0_cause_i[9:8];
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) status = wb_cp0_data_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) sw_ip  = wb_cp0_data_i[9:8];
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) epc    = wb_cp0_data_i;
      pend = {model_sync(), sw_ip} & status[15:8];
      if (pend != 0 && status[0] && !status[1]) code = 32'h1;
      else if (mem_excepttype_i[8])  code = 32'h8;
      else if (mem_excepttype_i[9])  code = 32'ha;
      else if (mem_excepttype_i[10]) code = 32'hd;
      else if (mem_excepttype_i[11]) code = 32'hc;
      else if (mem_excepttype_i[12]) code = 32'he;
      else                           code = 32'h0;
      if (rst) begin
         model_reset();
         return;
      end
      if (rem > 0) begin
         rem--;
         e_exc = 0;
         if (rem == 0) begin e_addr = 0; e_npc = 0; e_ds = 0; end
      end else if (mem_valid_i && code != 0) begin
         e_exc  = code;
         e_addr = mem_pc_i;
         e_ds   = mem_in_delayslot_i;
         e_npc  = (code == 32'he) ? epc : VEC;
         rem    = FC;
      end else begin
         e_exc = 0; e_addr = 0; e_npc = 0; e_ds = 0;
      end
      m_s2 = m_s1;
      m_s1 = int_i;
   endtask

   task automatic step();
      #1;
      check_val("int_sync", 32'(int_sync_o), 32'(model_sync()));
      model_edge();
      @(posedge clk);
      #1;
      check_val("excepttype", excepttype_o, e_exc);
      check_val("flush", 32'(flush_o), 32'(rem > 0));
      check_val("busy", 32'(busy_o), 32'(rem > 0));
      check_val("new_pc", new_pc_o, e_npc);
      if (rem == 0 || e_exc != 0) begin
         check_val("inst_addr", current_inst_addr_o, e_addr);
         check_val("delayslot", 32'(is_in_delayslot_o), 32'(e_ds));
      end
   endtask

   task automatic idle_inputs();
      int_i = 0; mem_valid_i = 0; mem_excepttype_i = 0; mem_pc_i = 0;
      mem_in_delayslot_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
      wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      check_val("rst_exc", excepttype_o, 32'h0);
      check_val("rst_flush", 32'(flush_o), 32'h0);
      rst = 1'b0;
      step();

      // Syscall
      mem_valid_i = 1; mem_excepttype_i = 32'h100; mem_pc_i = 32'h100;
      step();
      check_val("sys_code", excepttype_o, 32'h8);
      check_val("sys_addr", current_inst_addr_o, 32'h100);
      check_val("sys_npc", new_pc_o, 32'h20);
      idle_inputs();
      step();
      check_val("sys_exc_once", excepttype_o, 32'h0);
      check_val("sys_flush_2nd", 32'(flush_o), 32'h1);
      step();
      check_val("sys_flush_end", 32'(flush_o), 32'h0);

      // Eret with EPC forwarded from WB
      mem_valid_i = 1; mem_excepttype_i = 32'h1000; mem_pc_i = 32'h200; cp0_epc_i = 32'h999;
      wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h400;
      step();
      check_val("eret_code", excepttype_o, 32'he);
      check_val("eret_npc", new_pc_o, 32'h400);
      idle_inputs();
      step(); step();

      // Interrupt on line 0
      cp0_status_i = 32'h401; int_i = 6'h01;
      step(); step(); step();
      check_val("int_sync0", 32'(int_sync_o[0]), 32'h1);
      mem_valid_i = 1; mem_pc_i = 32'h500;
      step();
      check_val("int_code", excepttype_o, 32'h1);
      mem_valid_i = 0;
      step(); step();
      cp0_status_i = 32'h403; mem_valid_i = 1;
      step();
      check_val("int_exl", excepttype_o, 32'h0);

      // Priority: interrupt beats invalid/overflow; masked -> invalid
      cp0_status_i = 32'h401; mem_excepttype_i = 32'ha00;
      step();
      check_val("prio_int", excepttype_o, 32'h1);
      mem_valid_i = 0;
      step(); step();
      cp0_status_i = 32'h400; mem_valid_i = 1;
      step();
      check_val("prio_inv", excepttype_o, 32'ha);
      mem_valid_i = 0;
      step(); step();

      // WB clearing IE in the detection cycle suppresses the interrupt
      cp0_status_i = 32'h401; mem_excepttype_i = 0; mem_valid_i = 1;
      wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h400;
      step();
      check_val("fwd_ie_clr", excepttype_o, 32'h0);
      idle_inputs();
      step();

      // Flush window: held syscall is ignored until flush falls
      mem_valid_i = 1; mem_excepttype_i = 32'h100; mem_pc_i = 32'h300; mem_in_delayslot_i = 1;
      step();
      check_val("win_first", excepttype_o, 32'h8);
      check_val("win_ds", 32'(is_in_delayslot_o), 32'h1);
      step();
      step();
      check_val("win_ignored", excepttype_o, 32'h0);
      check_val("win_fell", 32'(flush_o), 32'h0);
      step();
      check_val("win_accept", excepttype_o, 32'h8);

      // Reset mid-flush
      rst = 1'b1;
      model_reset();
      #1;
      check_val("midrst_exc", excepttype_o, 32'h0);
      check_val("midrst_flush", 32'(flush_o), 32'h0);
      check_val("midrst_busy", 32'(busy_o), 32'h0);
      check_val("midrst_npc", new_pc_o, 32'h0);
      check_val("midrst_addr", current_inst_addr_o, 32'h0);
      step();
      rst = 1'b0;
      mem_pc_i = 32'h600; mem_in_delayslot_i = 0;
      step();
      check_val("postrst_sys", excepttype_o, 32'h8);
      idle_inputs();
      step(); step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (rst) model_reset();
         int_i = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h0;
         mem_valid_i = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0: mem_excepttype_i = 32'h0;
            1: mem_excepttype_i = 32'h1 << $urandom_range(8, 12);
            2: mem_excepttype_i = $urandom;
            default: mem_excepttype_i = $urandom & 32'hFFFF_E0FF;
         endcase
         mem_pc_i = $urandom;
         mem_in_delayslot_i = 1'($urandom);
         cp0_status_i = {16'h0, 8'($urandom), 6'h0,
                         1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
         cp0_cause_i = $urandom;
         cp0_epc_i = $urandom;
         wb_cp0_we_i = 1'($urandom);
         wb_cp0_waddr_i = 5'($urandom_range(11, 15));
         wb_cp0_data_i = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
